id_ex_stage: RTL

ID/EX pipeline stage that registers decoded instructions and presents operands and controls directly to the ALU (`input1`, `input2`, `ex_cmd`, `ALUOp`, `flag`, `branchD`). It resolves RAW hazards by forwarding results from EX/MEM and MEM/WB. It detects load-use hazards and inserts one-cycle bubbles, and it honours downstream stall and branch flush.

---
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register sitting in front of the ALU. Captures a decoded
//   instruction, forwards EX/MEM and MEM/WB results onto the operands,
//   detects load-use hazards (one bubble), and honours flush and stall.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_*                            decoded instruction in the ID slot
//   exm_reg_write/exm_rd/exm_result EX/MEM forwarding source
//   mwb_reg_write/mwb_rd/mwb_result MEM/WB forwarding source
//   flush                           kill the instruction being captured
//   ex_stall                        downstream hold request
//   id_stall                        upstream must hold IF/ID
//   ex_valid                        EX slot holds a real instruction
//   input1/input2                   ALU operands after forwarding/imm mux
//   ex_store_data                   forwarded rs2 value for stores
//   ex_cmd/ALUOp/flag/branchD       ALU controls
//   ex_rd/ex_mem_read/ex_reg_write  destination and memory/writeback controls
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [4:0]      id_ex_cmd,
    input  logic [1:0]      id_aluop,
    input  logic            id_flag,
    input  logic            id_branch,
    input  logic            id_mem_read,
    input  logic            id_reg_write,
    input  logic            exm_reg_write,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [REGW-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    input  logic            flush,
    input  logic            ex_stall,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] input1,
    output logic [XLEN-1:0] input2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_cmd,
    output logic [1:0]      ALUOp,
    output logic            flag,
    output logic            branchD,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_mem_read,
    output logic            ex_reg_write
);

    logic            valid_q, valid_d;
    logic [REGW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
    logic            use_imm_q, use_imm_d;
    logic [4:0]      cmd_q, cmd_d;
    logic [1:0]      aluop_q, aluop_d;
    logic            flag_q, flag_d, branch_q, branch_d;
    logic            mem_read_q, mem_read_d, reg_write_q, reg_write_d;

    logic lu;
    logic exm_hit1, exm_hit2, mwb_hit1, mwb_hit2;

    // A writeback qualifies only if it writes a register other than x0.
    function automatic logic src_hit(input logic            we,
                                     input logic [REGW-1:0] wr_rd,
                                     input logic [REGW-1:0] src);
        return we && (wr_rd != '0) && (wr_rd == src);
    endfunction

    assign exm_hit1 = valid_q & src_hit(exm_reg_write, exm_rd, rs1_q);
    assign exm_hit2 = valid_q & src_hit(exm_reg_write, exm_rd, rs2_q);
    assign mwb_hit1 = valid_q & src_hit(mwb_reg_write, mwb_rd, rs1_q);
    assign mwb_hit2 = valid_q & src_hit(mwb_reg_write, mwb_rd, rs2_q);

    // rs2 is compared even for immediate-form instructions (conservative).
    assign lu = valid_q & mem_read_q & reg_write_q & (rd_q != '0) & id_valid &
                ((id_rs1 == rd_q) | (id_rs2 == rd_q));

    // A flush discards the ID instruction, so its hazard must not stall IF/ID.
    assign id_stall = ex_stall | (lu & ~flush);

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        cmd_d       = cmd_q;
        aluop_d     = aluop_q;
        flag_d      = flag_q;
        branch_d    = branch_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ex_stall) begin
            // Sticky capture: the MEM/WB producer retires during the stall,
            // so latch its result now or the operand would go stale.
            if (mwb_hit1) op1_d = mwb_result;
            if (mwb_hit2) op2_d = mwb_result;
        end else if (lu) begin
            valid_d = 1'b0;
        end else begin
            valid_d     = id_valid;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            op1_d       = id_rdata1;
            op2_d       = id_rdata2;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            cmd_d       = id_ex_cmd;
            aluop_d     = id_aluop;
            flag_d      = id_flag;
            branch_d    = id_branch;
            mem_read_d  = id_mem_read;
            reg_write_d = id_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            cmd_q       <= '0;
            aluop_q     <= '0;
            flag_q      <= 1'b0;
            branch_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            cmd_q       <= cmd_d;
            aluop_q     <= aluop_d;
            flag_q      <= flag_d;
            branch_q    <= branch_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    assign input1        = exm_hit1 ? exm_result : (mwb_hit1 ? mwb_result : op1_q);
    assign ex_store_data = exm_hit2 ? exm_result : (mwb_hit2 ? mwb_result : op2_q);
    assign input2        = use_imm_q ? imm_q : ex_store_data;

    assign ex_valid     = valid_q;
    assign ex_cmd       = cmd_q;
    assign ALUOp        = aluop_q;
    assign flag         = flag_q;
    assign branchD      = branch_q;
    assign ex_rd        = rd_q;
    // Bubbles must not write back or touch memory.
    assign ex_mem_read  = mem_read_q & valid_q;
    assign ex_reg_write = reg_write_q & valid_q;

endmodule
